axi_slave_ram_bridge: RTL and testbench

AXI4 responder (slave) for the 32-bit, 4-bit-ID, 8-bit-len AXI port that the dcache AXI adapter drives as initiator. It converts AW/W/B and AR/R bursts into single-beat word requests on a simple RAM port and returns B/R responses with the original IDs. It sits at the memory end of the dcache path, e.g. in front of a TCM or simulation RAM model.

---
 rtl/axi_slave_ram_bridge_pkg.sv | 17 +
 rtl/axi_slave_ram_bridge.sv | 167 ++++++++++++++++
 tb/tb_axi_slave_ram_bridge.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/axi_slave_ram_bridge_pkg.sv
// axi_slave_ram_bridge_pkg: shared widths, FSM states and AXI response codes for the RAM bridge
package axi_slave_ram_bridge_pkg;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   localparam int ID_W   = 4;
   localparam int LEN_W  = 8;
   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_DATA,
      ST_WR_RESP,
      ST_RD_REQ,
      ST_RD_DATA
   } state_t;
endpackage

// File: rtl/axi_slave_ram_bridge.sv
// axi_slave_ram_bridge: AXI4 INCR-burst responder turning bursts into single-word RAM requests
module axi_slave_ram_bridge
   import axi_slave_ram_bridge_pkg::*;
#(
   parameter bit WR_FIRST = 1'b1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              inport_awvalid_i,
   input  logic [ADDR_W-1:0] inport_awaddr_i,
   input  logic [ID_W-1:0]   inport_awid_i,
   input  logic [LEN_W-1:0]  inport_awlen_i,
   output logic              inport_awready_o,
   input  logic              inport_wvalid_i,
   input  logic [DATA_W-1:0] inport_wdata_i,
   input  logic [STRB_W-1:0] inport_wstrb_i,
   input  logic              inport_wlast_i,
   output logic              inport_wready_o,
   output logic              inport_bvalid_o,
   output logic [1:0]        inport_bresp_o,
   output logic [ID_W-1:0]   inport_bid_o,
   input  logic              inport_bready_i,
   input  logic              inport_arvalid_i,
   input  logic [ADDR_W-1:0] inport_araddr_i,
   input  logic [ID_W-1:0]   inport_arid_i,
   input  logic [LEN_W-1:0]  inport_arlen_i,
   output logic              inport_arready_o,
   output logic              inport_rvalid_o,
   output logic [DATA_W-1:0] inport_rdata_o,
   output logic [1:0]        inport_rresp_o,
   output logic [ID_W-1:0]   inport_rid_o,
   output logic              inport_rlast_o,
   input  logic              inport_rready_i,
   output logic [STRB_W-1:0] outport_wr_o,
   output logic              outport_rd_o,
   output logic [ADDR_W-1:0] outport_addr_o,
   output logic [DATA_W-1:0] outport_wdata_o,
   input  logic              outport_ack_i,
   input  logic [DATA_W-1:0] outport_rdata_i,
   input  logic              outport_error_i
);
   state_t              state_q;
   logic                rr_wr_q, err_q, rd_q, bvalid_q, rvalid_q, rlast_q;
   logic [ID_W-1:0]     id_q;
   logic [LEN_W-1:0]    len_q, cnt_q;
   logic [STRB_W-1:0]   wr_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q, rdata_q;
   logic [1:0]          bresp_q, rresp_q;
   logic                grant_wr, w_hs, last, wr_ack, w_done, err_d;

   // Address arbitration, write-beat handshake and sticky write error next value
   always_comb begin
      grant_wr         = inport_awvalid_i && (!inport_arvalid_i || rr_wr_q);
      inport_awready_o = state_q == ST_IDLE && inport_awvalid_i && grant_wr;
      inport_arready_o = state_q == ST_IDLE && inport_arvalid_i && !grant_wr;
      inport_wready_o  = state_q == ST_WR_DATA && wr_q == '0;
      w_hs             = inport_wvalid_i && inport_wready_o;
      last             = cnt_q == len_q;
      wr_ack           = wr_q != '0 && outport_ack_i;
      w_done           = (w_hs && inport_wstrb_i == '0) || wr_ack;
      err_d            = err_q || (w_hs && inport_wlast_i != last) || (wr_ack && outport_error_i);
   end

   // Burst FSM with beat counter, RAM request registers and registered AXI responses
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         rr_wr_q  <= WR_FIRST;
         err_q    <= 1'b0;
         rd_q     <= 1'b0;
         bvalid_q <= 1'b0;
         rvalid_q <= 1'b0;
         rlast_q  <= 1'b0;
         id_q     <= '0;
         len_q    <= '0;
         cnt_q    <= '0;
         wr_q     <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         bresp_q  <= AXI_RESP_OKAY;
         rresp_q  <= AXI_RESP_OKAY;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (inport_awready_o) begin
                  addr_q  <= inport_awaddr_i & ~32'h3;
                  id_q    <= inport_awid_i;
                  len_q   <= inport_awlen_i;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
                  rr_wr_q <= 1'b0;
                  state_q <= ST_WR_DATA;
               end else if (inport_arready_o) begin
                  addr_q  <= inport_araddr_i & ~32'h3;
                  id_q    <= inport_arid_i;
                  len_q   <= inport_arlen_i;
                  cnt_q   <= '0;
                  err_q   <= 1'b0;
                  rr_wr_q <= 1'b1;
                  rd_q    <= 1'b1;
                  state_q <= ST_RD_REQ;
               end
            end
            ST_WR_DATA: begin
               err_q <= err_d;
               if (w_hs && inport_wstrb_i != '0) begin
                  wr_q    <= inport_wstrb_i;
                  wdata_q <= inport_wdata_i;
               end
               if (wr_ack) wr_q <= '0;
               if (w_done && last) begin
                  bvalid_q <= 1'b1;
                  bresp_q  <= err_d ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                  state_q  <= ST_WR_RESP;
               end else if (w_done) begin
                  cnt_q  <= cnt_q + 8'd1;
                  addr_q <= addr_q + 32'd4;
               end
            end
            ST_WR_RESP: begin
               if (inport_bready_i) begin
                  bvalid_q <= 1'b0;
                  state_q  <= ST_IDLE;
               end
            end
            ST_RD_REQ: begin
               if (outport_ack_i) begin
                  rd_q     <= 1'b0;
                  rdata_q  <= outport_rdata_i;
                  rresp_q  <= outport_error_i ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                  rlast_q  <= last;
                  rvalid_q <= 1'b1;
                  state_q  <= ST_RD_DATA;
               end
            end
            ST_RD_DATA: begin
               if (inport_rready_i) begin
                  rvalid_q <= 1'b0;
                  if (rlast_q) state_q <= ST_IDLE;
                  else begin
                     cnt_q   <= cnt_q + 8'd1;
                     addr_q  <= addr_q + 32'd4;
                     rd_q    <= 1'b1;
                     state_q <= ST_RD_REQ;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign inport_bvalid_o = bvalid_q;
   assign inport_bresp_o  = bresp_q;
   assign inport_bid_o    = id_q;
   assign inport_rvalid_o = rvalid_q;
   assign inport_rdata_o  = rdata_q;
   assign inport_rresp_o  = rresp_q;
   assign inport_rid_o    = id_q;
   assign inport_rlast_o  = rlast_q;
   assign outport_wr_o    = wr_q;
   assign outport_rd_o    = rd_q;
   assign outport_addr_o  = addr_q;
   assign outport_wdata_o = wdata_q;
endmodule

// File: tb/tb_axi_slave_ram_bridge.sv
// tb_axi_slave_ram_bridge: directed AXI burst vectors against a zero-wait RAM model
module tb_axi_slave_ram_bridge;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        awvalid, awready, wvalid, wlast, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rlast, rready, rd, ack, ram_err;
   logic [31:0] awaddr, araddr, wdata, rdata, addr, ram_wdata, ram_rdata;
   logic [3:0]  awid, arid, bid, rid, wstrb, wr;
   logic [7:0]  awlen, arlen;
   logic [1:0]  bresp, rresp;
   logic        ack_en;
   logic [31:0] err_addr;
   logic [31:0] mem [0:1023];
   logic [31:0] wlog [$];
   logic [31:0] rlog [$];
   int          checks = 0;
   int          errors = 0;
   int          n;

   always #5 clk = ~clk;

   assign ack       = ack_en && (wr != 4'h0 || rd);
   assign ram_rdata = mem[addr[11:2]];
   assign ram_err   = ack && addr == err_addr;

   axi_slave_ram_bridge #(.WR_FIRST(1'b1)) dut (
      .clk_i(clk), .rst_ni(rst_n),
      .inport_awvalid_i(awvalid), .inport_awaddr_i(awaddr), .inport_awid_i(awid),
      .inport_awlen_i(awlen), .inport_awready_o(awready),
      .inport_wvalid_i(wvalid), .inport_wdata_i(wdata), .inport_wstrb_i(wstrb),
      .inport_wlast_i(wlast), .inport_wready_o(wready),
      .inport_bvalid_o(bvalid), .inport_bresp_o(bresp), .inport_bid_o(bid),
      .inport_bready_i(bready),
      .inport_arvalid_i(arvalid), .inport_araddr_i(araddr), .inport_arid_i(arid),
      .inport_arlen_i(arlen), .inport_arready_o(arready),
      .inport_rvalid_o(rvalid), .inport_rdata_o(rdata), .inport_rresp_o(rresp),
      .inport_rid_o(rid), .inport_rlast_o(rlast), .inport_rready_i(rready),
      .outport_wr_o(wr), .outport_rd_o(rd), .outport_addr_o(addr),
      .outport_wdata_o(ram_wdata), .outport_ack_i(ack),
      .outport_rdata_i(ram_rdata), .outport_error_i(ram_err)
   );

   // RAM model: applies byte writes and logs every completed request address
   always @(negedge clk) begin
      if (ack && wr != 4'h0) begin
         wlog.push_back(addr);
         for (int b = 0; b < 4; b++) if (wr[b]) mem[addr[11:2]][8*b +: 8] = ram_wdata[8*b +: 8];
      end
      if (ack && rd) rlog.push_back(addr);
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
      awvalid = 1'b1; awid = id; awaddr = a; awlen = len;
      for (int i = 0; i < 50; i++) begin #1; if (awready) break; @(negedge clk); end
      chk("awready", {31'd0, awready}, 32'd1);
      @(posedge clk); @(negedge clk);
      awvalid = 1'b0;
   endtask

   task automatic ar_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
      arvalid = 1'b1; arid = id; araddr = a; arlen = len;
      for (int i = 0; i < 50; i++) begin #1; if (arready) break; @(negedge clk); end
      chk("arready", {31'd0, arready}, 32'd1);
      @(posedge clk); @(negedge clk);
      arvalid = 1'b0;
   endtask

   task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
      wvalid = 1'b1; wdata = d; wstrb = s; wlast = l;
      for (int i = 0; i < 50; i++) begin #1; if (wready) break; @(negedge clk); end
      chk("wready", {31'd0, wready}, 32'd1);
      @(posedge clk); @(negedge clk);
      wvalid = 1'b0;
   endtask

   task automatic b_recv(input logic [1:0] resp, input logic [3:0] id);
      bready = 1'b1;
      for (int i = 0; i < 50; i++) begin #1; if (bvalid) break; @(negedge clk); end
      chk("bvalid", {31'd0, bvalid}, 32'd1);
      chk("bresp", {30'd0, bresp}, {30'd0, resp});
      chk("bid", {28'd0, bid}, {28'd0, id});
      @(posedge clk); @(negedge clk);
      bready = 1'b0;
   endtask

   task automatic r_recv(input logic [31:0] d, input logic [1:0] resp, input logic l,
                         input logic [3:0] id, input int stall);
      rready = 1'b0;
      for (int i = 0; i < 50; i++) begin #1; if (rvalid) break; @(negedge clk); end
      chk("rvalid", {31'd0, rvalid}, 32'd1);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk); #1;
         chk("rvalid_stall", {31'd0, rvalid}, 32'd1);
         chk("rdata_stall", rdata, d);
         chk("rid_stall", {28'd0, rid}, {28'd0, id});
      end
      rready = 1'b1;
      chk("rdata", rdata, d);
      chk("rresp", {30'd0, rresp}, {30'd0, resp});
      chk("rlast", {31'd0, rlast}, {31'd0, l});
      chk("rid", {28'd0, rid}, {28'd0, id});
      @(posedge clk); @(negedge clk);
      rready = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_wr"}, {28'd0, wr}, 32'd0);
      chk({tag, "_rd"}, {31'd0, rd}, 32'd0);
      chk({tag, "_addr"}, addr, 32'd0);
      chk({tag, "_wdata"}, ram_wdata, 32'd0);
      chk({tag, "_bvalid"}, {31'd0, bvalid}, 32'd0);
      chk({tag, "_rvalid"}, {31'd0, rvalid}, 32'd0);
      chk({tag, "_wready"}, {31'd0, wready}, 32'd0);
      chk({tag, "_rdata"}, rdata, 32'd0);
      chk({tag, "_ids"}, {24'd0, bid, rid}, 32'd0);
      chk({tag, "_resps"}, {28'd0, bresp, rresp}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[128] = 32'hAAAA5555;
      mem[129] = 32'h12345678;
      for (int i = 0; i < 3; i++) mem[320 + i] = 32'h55000000 + i;
      rst_n = 1'b0; ack_en = 1'b1; err_addr = 32'hFFFFFFFF;
      awvalid = 0; awaddr = 0; awid = 0; awlen = 0;
      wvalid = 0; wdata = 0; wstrb = 0; wlast = 0; bready = 0;
      arvalid = 0; araddr = 0; arid = 0; arlen = 0; rready = 0;
      repeat (3) @(negedge clk);
      chk_quiet("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // simultaneous AW/AR: write first, then read
      awvalid = 1; awid = 4'd1; awaddr = 32'h300; awlen = 8'd0;
      arvalid = 1; arid = 4'd2; araddr = 32'h300; arlen = 8'd0;
      #1;
      chk("arb1_aw", {31'd0, awready}, 32'd1);
      chk("arb1_ar", {31'd0, arready}, 32'd0);
      @(posedge clk); @(negedge clk);
      awvalid = 0;
      w_send(32'hCAFEF00D, 4'hF, 1'b1);
      b_recv(2'b00, 4'd1);
      awvalid = 1; awid = 4'd4; awaddr = 32'h308; awlen = 8'd0;
      #1;
      chk("arb2_ar", {31'd0, arready}, 32'd1);
      chk("arb2_aw", {31'd0, awready}, 32'd0);
      @(posedge clk); @(negedge clk);
      arvalid = 0;
      r_recv(32'hCAFEF00D, 2'b00, 1'b1, 4'd2, 0);
      aw_send(4'd4, 32'h308, 8'd0);
      w_send(32'h11112222, 4'hF, 1'b1);
      b_recv(2'b00, 4'd4);

      // four-beat write burst
      wlog.delete();
      aw_send(4'd3, 32'h100, 8'd3);
      for (int i = 0; i < 4; i++) w_send(32'hD0D0_0000 + i, 4'hF, i == 3);
      b_recv(2'b00, 4'd3);
      chk("wr4_count", wlog.size(), 32'd4);
      for (int i = 0; i < 4; i++) chk("wr4_addr", wlog[i], 32'h100 + 4 * i);
      chk("wr4_mem2", mem[66], 32'hD0D00002);

      // two-beat read with stalled R channel
      rlog.delete();
      ar_send(4'd5, 32'h203, 8'd1);
      r_recv(32'hAAAA5555, 2'b00, 1'b0, 4'd5, 3);
      r_recv(32'h12345678, 2'b00, 1'b1, 4'd5, 0);
      chk("rd2_count", rlog.size(), 32'd2);
      chk("rd2_addr0", rlog[0], 32'h200);
      chk("rd2_addr1", rlog[1], 32'h204);

      // null-strobe single beat with wrong wlast
      n = wlog.size();
      aw_send(4'd6, 32'h400, 8'd0);
      w_send(32'h99999999, 4'h0, 1'b0);
      b_recv(2'b10, 4'd6);
      chk("nostrb_nowrite", wlog.size(), n);

      // read burst with an error on the middle beat
      err_addr = 32'h504;
      ar_send(4'd9, 32'h500, 8'd2);
      r_recv(32'h55000000, 2'b00, 1'b0, 4'd9, 0);
      r_recv(32'h55000001, 2'b10, 1'b0, 4'd9, 0);
      r_recv(32'h55000002, 2'b00, 1'b1, 4'd9, 0);
      aw_send(4'd10, 32'h504, 8'd0);
      w_send(32'h77777777, 4'h3, 1'b1);
      b_recv(2'b10, 4'd10);
      err_addr = 32'hFFFFFFFF;

      // reset in the middle of a long write burst
      aw_send(4'd7, 32'h600, 8'd7);
      w_send(32'h60000000, 4'hF, 1'b0);
      @(negedge clk);
      ack_en = 1'b0;
      w_send(32'h60000001, 4'hF, 1'b0);
      chk("mid_wr_pending", {28'd0, wr}, 32'hF);
      chk("mid_addr", addr, 32'h604);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      chk_quiet("midrst");
      rst_n = 1'b1; ack_en = 1'b1;
      ar_send(4'd8, 32'h100, 8'd0);
      r_recv(32'hD0D00000, 2'b00, 1'b1, 4'd8, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
